// File: rtl/rv64_decode_exec_if.sv
// Decode/execute slice bundle: fetched instruction and operands in,
// immediate, ALU result and control strobes out.
interface rv64_decode_exec_if #(
  parameter int XLEN = 64
);
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] imm;
  logic [2:0]      imm_sel;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_res;
  logic            rf_wen;
  logic            ebreak;
  logic            illegal;
  logic            halted;

  modport master (
    output inst, pc, rs1_data,
    input  imm, imm_sel, alu_sel, alu_res, rf_wen, ebreak, illegal, halted
  );

  modport slave (
    input  inst, pc, rs1_data,
    output imm, imm_sel, alu_sel, alu_res, rf_wen, ebreak, illegal, halted
  );
endinterface

// File: rtl/rv64_decode_exec.sv
// Single-cycle RV64I decode/execute: control decode, immediate generation and
// 64-bit ALU. The sticky halt flag set by ebreak is the only state.
module rv64_decode_exec #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  rv64_decode_exec_if.slave   bus
);
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_SYS   = 7'b1110011;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
                         IMM_U = 3'd3, IMM_J = 3'd4, IMM_NONE = 3'd5;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                         ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9;

  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_t;
  typedef enum logic       {SRC_B_IMM, SRC_B_FOUR} src_b_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [5:0]      funct6;
  logic [2:0]      imm_sel;
  logic [3:0]      alu_sel;
  logic            wen_dec;
  logic            illegal;
  src_a_t          src_a;
  src_b_t          src_b;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [5:0]      shamt;
  logic            is_ebreak;
  logic            halted_reg;

  assign opcode    = bus.inst[6:0];
  assign funct3    = bus.inst[14:12];
  assign funct6    = bus.inst[31:26];
  assign is_ebreak = (bus.inst == EBREAK_INST);

  always_comb begin
    imm_sel = IMM_NONE;
    alu_sel = ALU_ADD;
    wen_dec = 1'b0;
    illegal = 1'b0;
    src_a   = SRC_A_RS1;
    src_b   = SRC_B_IMM;
    case (opcode)
      OP_IMM: begin
        imm_sel = IMM_I;
        wen_dec = 1'b1;
        case (funct3)
          3'b000: alu_sel = ALU_ADD;
          3'b010: alu_sel = ALU_SLT;
          3'b011: alu_sel = ALU_SLTU;
          3'b100: alu_sel = ALU_XOR;
          3'b110: alu_sel = ALU_OR;
          3'b111: alu_sel = ALU_AND;
          3'b001: if (funct6 == 6'b000000) alu_sel = ALU_SLL;
                  else illegal = 1'b1;
          default: begin
            if (funct6 == 6'b000000)      alu_sel = ALU_SRL;
            else if (funct6 == 6'b010000) alu_sel = ALU_SRA;
            else                          illegal = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        src_a   = SRC_A_ZERO;
        wen_dec = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        src_a   = SRC_A_PC;
        wen_dec = 1'b1;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        src_a   = SRC_A_PC;
        src_b   = SRC_B_FOUR;
        wen_dec = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          imm_sel = IMM_I;
          src_a   = SRC_A_PC;
          src_b   = SRC_B_FOUR;
          wen_dec = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      // Memory and branch ops only compute rs1+imm; the target/address is used elsewhere
      OP_STORE: imm_sel = IMM_S;
      OP_BR:    imm_sel = IMM_B;
      OP_LOAD:  imm_sel = IMM_I;
      OP_SYS:   illegal = !is_ebreak;
      default:  illegal = 1'b1;
    endcase
    if (illegal) begin
      imm_sel = IMM_NONE;
      alu_sel = ALU_ADD;
      wen_dec = 1'b0;
    end
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
      IMM_S:   imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
      IMM_B:   imm = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                      bus.inst[30:25], bus.inst[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){bus.inst[31]}}, bus.inst[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                      bus.inst[20], bus.inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    case (src_a)
      SRC_A_PC:   op_a = bus.pc;
      SRC_A_ZERO: op_a = '0;
      default:    op_a = bus.rs1_data;
    endcase
    op_b = (src_b == SRC_B_FOUR) ? XLEN'(4) : imm;
  end

  assign shamt = op_b[5:0];

  always_comb begin
    case (alu_sel)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      halted_reg <= 1'b0;
    else if (is_ebreak && !halted_reg)
      halted_reg <= 1'b1;
  end

  // Once halted the slice keeps computing but must not retire anything
  assign bus.rf_wen  = wen_dec && !halted_reg;
  assign bus.ebreak  = is_ebreak && !halted_reg;
  assign bus.illegal = illegal;
  assign bus.halted  = halted_reg;
  assign bus.imm     = imm;
  assign bus.imm_sel = imm_sel;
  assign bus.alu_sel = alu_sel;
  assign bus.alu_res = alu_res;
endmodule

// File: tb/tb_rv64_decode_exec.sv
// Directed self-checking bench for rv64_decode_exec: hand-encoded RV64I
// instructions with hand-computed immediates, results and control outputs.
module tb_rv64_decode_exec;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asserts  = 0;
  int   failures = 0;

  rv64_decode_exec_if #(.XLEN(64)) bus ();

  rv64_decode_exec #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r);
    bus.inst     = i;
    bus.pc       = p;
    bus.rs1_data = r;
    #1;
  endtask

  task automatic test_reset;
    apply(32'h0050_0093, 64'h0, 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    asserts++;
    if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    $display("reset: halted=%b", bus.halted);
  endtask

  task automatic test_addi;
    apply(32'h0050_0093, 64'h0, 64'h0);
    asserts += 4;
    if (bus.imm_sel !== 3'd0) begin failures++; $display("FAIL addi_imm_sel got %0d want 0", bus.imm_sel); end
    if (bus.imm !== 64'd5) begin failures++; $display("FAIL addi_imm got %h want 5", bus.imm); end
    if (bus.alu_res !== 64'd5) begin failures++; $display("FAIL addi_res got %h want 5", bus.alu_res); end
    if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL addi_wen got %b want 1", bus.rf_wen); end
    $display("addi 5: imm=%h res=%h wen=%b", bus.imm, bus.alu_res, bus.rf_wen);
    apply(32'hFFF0_0093, 64'h0, 64'h1);
    asserts += 3;
    if (bus.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL addi_neg_imm got %h want ffffffffffffffff", bus.imm); end
    if (bus.alu_res !== 64'h0) begin failures++; $display("FAIL addi_neg_res got %h want 0", bus.alu_res); end
    if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL addi_neg_wen got %b want 1", bus.rf_wen); end
    $display("addi -1: imm=%h res=%h", bus.imm, bus.alu_res);
  endtask

  task automatic test_lui;
    apply(32'h1234_50B7, 64'h0, 64'hDEAD_BEEF);
    asserts += 3;
    if (bus.imm_sel !== 3'd3) begin failures++; $display("FAIL lui_imm_sel got %0d want 3", bus.imm_sel); end
    if (bus.imm !== 64'h0000_0000_1234_5000) begin failures++; $display("FAIL lui_imm got %h want 12345000", bus.imm); end
    if (bus.alu_res !== 64'h0000_0000_1234_5000) begin failures++; $display("FAIL lui_res got %h want 12345000", bus.alu_res); end
    $display("lui: imm=%h res=%h", bus.imm, bus.alu_res);
    apply(32'h8000_00B7, 64'h0, 64'h0);
    asserts += 2;
    if (bus.imm !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL lui_neg_imm got %h want ffffffff80000000", bus.imm); end
    if (bus.alu_res !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL lui_neg_res got %h want ffffffff80000000", bus.alu_res); end
    $display("lui neg: imm=%h res=%h", bus.imm, bus.alu_res);
  endtask

  task automatic test_pc_relative;
    apply(32'h0000_1097, 64'h8000_0000, 64'h0);
    asserts += 2;
    if (bus.alu_res !== 64'h8000_1000) begin failures++; $display("FAIL auipc_res got %h want 80001000", bus.alu_res); end
    if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL auipc_wen got %b want 1", bus.rf_wen); end
    $display("auipc: res=%h", bus.alu_res);
    apply(32'h0080_00EF, 64'h8000_0000, 64'h0);
    asserts += 4;
    if (bus.imm_sel !== 3'd4) begin failures++; $display("FAIL jal_imm_sel got %0d want 4", bus.imm_sel); end
    if (bus.imm !== 64'd8) begin failures++; $display("FAIL jal_imm got %h want 8", bus.imm); end
    if (bus.alu_res !== 64'h8000_0004) begin failures++; $display("FAIL jal_res got %h want 80000004", bus.alu_res); end
    if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL jal_wen got %b want 1", bus.rf_wen); end
    $display("jal: imm=%h res=%h", bus.imm, bus.alu_res);
    apply(32'h0001_00E7, 64'h1000, 64'h5555);
    asserts += 2;
    if (bus.alu_res !== 64'h1004) begin failures++; $display("FAIL jalr_res got %h want 1004", bus.alu_res); end
    if (bus.illegal !== 1'b0) begin failures++; $display("FAIL jalr_illegal got %b want 0", bus.illegal); end
    $display("jalr: res=%h", bus.alu_res);
  endtask

  task automatic test_mem_branch;
    apply(32'h0020_B423, 64'h0, 64'h100);
    asserts += 4;
    if (bus.imm_sel !== 3'd1) begin failures++; $display("FAIL sd_imm_sel got %0d want 1", bus.imm_sel); end
    if (bus.imm !== 64'd8) begin failures++; $display("FAIL sd_imm got %h want 8", bus.imm); end
    if (bus.alu_res !== 64'h108) begin failures++; $display("FAIL sd_res got %h want 108", bus.alu_res); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL sd_wen got %b want 0", bus.rf_wen); end
    $display("sd +8: imm=%h res=%h", bus.imm, bus.alu_res);
    apply(32'hFE20_BE23, 64'h0, 64'h100);
    asserts += 2;
    if (bus.imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL sd_neg_imm got %h want fffffffffffffffc", bus.imm); end
    if (bus.alu_res !== 64'hFC) begin failures++; $display("FAIL sd_neg_res got %h want fc", bus.alu_res); end
    $display("sd -4: imm=%h res=%h", bus.imm, bus.alu_res);
    apply(32'hFE20_8CE3, 64'h0, 64'h100);
    asserts += 3;
    if (bus.imm_sel !== 3'd2) begin failures++; $display("FAIL beq_imm_sel got %0d want 2", bus.imm_sel); end
    if (bus.imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL beq_imm got %h want fffffffffffffff8", bus.imm); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL beq_wen got %b want 0", bus.rf_wen); end
    $display("beq -8: imm=%h", bus.imm);
    apply(32'h0101_3083, 64'h0, 64'h20);
    asserts += 2;
    if (bus.alu_res !== 64'h30) begin failures++; $display("FAIL ld_res got %h want 30", bus.alu_res); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL ld_wen got %b want 0", bus.rf_wen); end
    $display("ld +16: res=%h", bus.alu_res);
  endtask

  task automatic test_alu_ops;
    apply(32'h0010_A093, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    asserts += 2;
    if (bus.alu_sel !== 4'd3) begin failures++; $display("FAIL slti_sel got %0d want 3", bus.alu_sel); end
    if (bus.alu_res !== 64'd1) begin failures++; $display("FAIL slti_res got %h want 1", bus.alu_res); end
    $display("slti: res=%h", bus.alu_res);
    apply(32'h0010_B093, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    asserts += 2;
    if (bus.alu_sel !== 4'd4) begin failures++; $display("FAIL sltiu_sel got %0d want 4", bus.alu_sel); end
    if (bus.alu_res !== 64'd0) begin failures++; $display("FAIL sltiu_res got %h want 0", bus.alu_res); end
    $display("sltiu: res=%h", bus.alu_res);
    apply(32'hFFF0_C093, 64'h0, 64'h0F0F);
    asserts++;
    if (bus.alu_res !== 64'hFFFF_FFFF_FFFF_F0F0) begin failures++; $display("FAIL xori_res got %h want fffffffffffff0f0", bus.alu_res); end
    $display("xori: res=%h", bus.alu_res);
    apply(32'h0FF0_E093, 64'h0, 64'h1234);
    asserts++;
    if (bus.alu_res !== 64'h12FF) begin failures++; $display("FAIL ori_res got %h want 12ff", bus.alu_res); end
    $display("ori: res=%h", bus.alu_res);
    apply(32'h0FF0_F093, 64'h0, 64'h1234);
    asserts++;
    if (bus.alu_res !== 64'h34) begin failures++; $display("FAIL andi_res got %h want 34", bus.alu_res); end
    $display("andi: res=%h", bus.alu_res);
    apply(32'h03F0_9093, 64'h0, 64'h1);
    asserts++;
    if (bus.alu_res !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL slli63_res got %h want 8000000000000000", bus.alu_res); end
    $display("slli 63: res=%h", bus.alu_res);
    apply(32'h0040_D093, 64'h0, 64'h8000_0000_0000_0000);
    asserts++;
    if (bus.alu_res !== 64'h0800_0000_0000_0000) begin failures++; $display("FAIL srli_res got %h want 0800000000000000", bus.alu_res); end
    $display("srli 4: res=%h", bus.alu_res);
    apply(32'h4010_D093, 64'h0, 64'h8000_0000_0000_0000);
    asserts += 2;
    if (bus.alu_sel !== 4'd7) begin failures++; $display("FAIL srai_sel got %0d want 7", bus.alu_sel); end
    if (bus.alu_res !== 64'hC000_0000_0000_0000) begin failures++; $display("FAIL srai_res got %h want c000000000000000", bus.alu_res); end
    $display("srai 1: res=%h", bus.alu_res);
  endtask

  task automatic test_illegal;
    apply(32'h0000_0000, 64'h0, 64'h0);
    asserts += 2;
    if (bus.illegal !== 1'b1) begin failures++; $display("FAIL zero_illegal got %b want 1", bus.illegal); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL zero_wen got %b want 0", bus.rf_wen); end
    $display("inst 0: illegal=%b", bus.illegal);
    apply(32'h4010_9093, 64'h0, 64'h1);
    asserts += 3;
    if (bus.illegal !== 1'b1) begin failures++; $display("FAIL bad_slli_illegal got %b want 1", bus.illegal); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL bad_slli_wen got %b want 0", bus.rf_wen); end
    if (bus.imm !== 64'h0) begin failures++; $display("FAIL bad_slli_imm got %h want 0", bus.imm); end
    $display("bad slli: illegal=%b", bus.illegal);
    apply(32'h0001_10E7, 64'h1000, 64'h0);
    asserts += 2;
    if (bus.illegal !== 1'b1) begin failures++; $display("FAIL bad_jalr_illegal got %b want 1", bus.illegal); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL bad_jalr_wen got %b want 0", bus.rf_wen); end
    $display("jalr f3=1: illegal=%b", bus.illegal);
    apply(32'h0000_0073, 64'h0, 64'h0);
    asserts += 2;
    if (bus.illegal !== 1'b1) begin failures++; $display("FAIL ecall_illegal got %b want 1", bus.illegal); end
    if (bus.ebreak !== 1'b0) begin failures++; $display("FAIL ecall_ebreak got %b want 0", bus.ebreak); end
    $display("ecall: illegal=%b", bus.illegal);
  endtask

  task automatic test_ebreak_halt;
    apply(32'h0010_0073, 64'h0, 64'h0);
    asserts += 3;
    if (bus.ebreak !== 1'b1) begin failures++; $display("FAIL ebreak_strobe got %b want 1", bus.ebreak); end
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL ebreak_wen got %b want 0", bus.rf_wen); end
    if (bus.illegal !== 1'b0) begin failures++; $display("FAIL ebreak_illegal got %b want 0", bus.illegal); end
    $display("ebreak: ebreak=%b", bus.ebreak);
    @(posedge clk); #1;
    asserts += 2;
    if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_set got %b want 1", bus.halted); end
    if (bus.ebreak !== 1'b0) begin failures++; $display("FAIL halt_ebreak got %b want 0", bus.ebreak); end
    $display("after ebreak edge: halted=%b ebreak=%b", bus.halted, bus.ebreak);
    apply(32'h0050_0093, 64'h0, 64'h0);
    @(posedge clk); #1;
    asserts += 3;
    if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL halt_wen got %b want 0", bus.rf_wen); end
    if (bus.alu_res !== 64'd5) begin failures++; $display("FAIL halt_res got %h want 5", bus.alu_res); end
    if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got %b want 1", bus.halted); end
    $display("halted addi: wen=%b res=%h", bus.rf_wen, bus.alu_res);
    rst = 1'b1;
    bus.inst = 32'h0010_0073;
    @(posedge clk); #1;
    rst = 1'b0;
    asserts++;
    if (bus.halted !== 1'b0) begin failures++; $display("FAIL rst_wins got %b want 0", bus.halted); end
    $display("reset with ebreak: halted=%b", bus.halted);
    apply(32'h0050_0093, 64'h0, 64'h0);
    @(posedge clk); #1;
    asserts += 2;
    if (bus.halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b want 0", bus.halted); end
    if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL rst_wen got %b want 1", bus.rf_wen); end
    $display("after reset addi: wen=%b", bus.rf_wen);
  endtask

  initial begin
    bus.inst     = 32'h0;
    bus.pc       = 64'h0;
    bus.rs1_data = 64'h0;
    test_reset();
    test_addi();
    test_lui();
    test_pc_relative();
    test_mem_branch();
    test_alu_ops();
    test_illegal();
    test_ebreak_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
